// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module  : seq_det_pkg
// Brief   : Shared FSM states and power-on pattern/mask for masked_seq_detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2
    } state_t;

    // 10X1 pattern; wider LEN values see it zero-extended in the upper bits.
    localparam logic [15:0] c_DEF_PATTERN = 16'h0009;
    localparam logic [15:0] c_DEF_MASK    = 16'h000D;

endpackage

`default_nettype wire

// File: rtl/seq_det_history.sv
// ============================================================================
// Module  : seq_det_history
// Brief   : History shift register, saturating fill counter and masked compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_history #(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_flush,
    input  logic           i_shift,
    input  logic           i_x,
    input  logic           i_overlap,
    input  logic [LEN-1:0] i_pattern,
    input  logic [LEN-1:0] i_mask,
    output logic           o_match,
    output logic           o_full_next,
    output logic           o_filled
);

    localparam int FILL_W = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] c_FILL_MAX = FILL_W'(LEN);

    logic [LEN-1:0]    r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [LEN-1:0]    w_hist_next;
    logic [FILL_W-1:0] w_fill_next;

    assign w_hist_next = {r_hist[LEN-2:0], i_x};
    assign w_fill_next = (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;
    assign o_full_next = (w_fill_next == c_FILL_MAX);
    assign o_filled    = (r_fill == c_FILL_MAX);
    assign o_match     = i_shift && o_full_next &&
                         (((w_hist_next ^ i_pattern) & i_mask) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_flush) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_next;
            // Non-overlap mode demands LEN fresh bits after every match.
            r_fill <= (o_match && !i_overlap) ? '0 : w_fill_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/masked_seq_detector.sv
// ============================================================================
// Module  : masked_seq_detector
// Brief   : Serial masked-pattern detector with Moore match flag and counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module masked_seq_detector
    import seq_det_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             clear,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   pattern,
    input  logic [LEN-1:0]   mask,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    logic             r_rst_meta;
    logic             r_rst_sync;
    state_t           r_state;
    logic             r_z;
    logic [CNT_W-1:0] r_count;
    logic [LEN-1:0]   r_pattern;
    logic [LEN-1:0]   r_mask;
    logic             r_overlap;

    logic w_flush;
    logic w_shift;
    logic w_match;
    logic w_full_next;
    logic w_filled;

    // Assertion is immediate; release is re-timed to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_flush = clear | cfg_load;
    assign w_shift = x_valid & ~w_flush;

    seq_det_history #(
        .LEN (LEN)
    ) u_history (
        .clk         (clk),
        .reset       (r_rst_sync),
        .i_flush     (w_flush),
        .i_shift     (w_shift),
        .i_x         (x),
        .i_overlap   (r_overlap),
        .i_pattern   (r_pattern),
        .i_mask      (r_mask),
        .o_match     (w_match),
        .o_full_next (w_full_next),
        .o_filled    (w_filled)
    );

    always_ff @(posedge clk or posedge r_rst_sync) begin
        if (r_rst_sync) begin
            r_state   <= ST_FILL;
            r_z       <= 1'b0;
            r_count   <= '0;
            r_pattern <= c_DEF_PATTERN[LEN-1:0];
            r_mask    <= c_DEF_MASK[LEN-1:0];
            r_overlap <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_pattern <= pattern;
                r_mask    <= mask;
                r_overlap <= overlap;
            end
            if (clear) begin
                r_count <= '0;
            end
            if (w_flush) begin
                r_state <= ST_FILL;
                r_z     <= 1'b0;
            end else if (x_valid) begin
                if (w_match) begin
                    r_state <= ST_HIT;
                    r_z     <= 1'b1;
                    if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    r_state <= w_full_next ? ST_ARMED : ST_FILL;
                    r_z     <= 1'b0;
                end
            end else if (r_state == ST_HIT) begin
                r_state <= w_filled ? ST_ARMED : ST_FILL;
                r_z     <= 1'b0;
            end
        end
    end

    assign z           = r_z;
    assign match_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_masked_seq_detector.sv
// ============================================================================
// Module  : tb_masked_seq_detector
// Brief   : Directed and random stimulus against an integer reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_masked_seq_detector;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic       x_valid;
    logic       clear;
    logic       cfg_load;
    logic [3:0] pattern;
    logic [3:0] mask;
    logic       overlap;
    logic       z;
    logic       z2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_checks = 0;
    int n_errors = 0;

    int m_hist, m_fill, m_pat, m_mask, m_ovl, m_cnt, m_cnt2;
    bit m_z;

    always #5 clk = ~clk;

    masked_seq_detector #(.LEN(LEN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
        .cfg_load(cfg_load), .pattern(pattern), .mask(mask), .overlap(overlap),
        .z(z), .match_count(cnt)
    );

    masked_seq_detector #(.LEN(LEN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear(clear),
        .cfg_load(cfg_load), .pattern(pattern), .mask(mask), .overlap(overlap),
        .z(z2), .match_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 9; m_mask = 13; m_ovl = 0;
        m_hist = 0; m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_z = 0;
    endtask

    // One clock: drive, let the edge pass, advance the model, compare.
    task automatic step(input bit xv, input bit xb, input bit cl = 0, input bit ld = 0,
                        input int pat = 0, input int msk = 0, input int ovl = 0);
        bit hit;
        x_valid  = xv;
        x        = xb;
        clear    = cl;
        cfg_load = ld;
        pattern  = 4'(pat);
        mask     = 4'(msk);
        overlap  = ovl[0];
        @(posedge clk);
        if (ld) begin
            m_pat = pat & 15; m_mask = msk & 15; m_ovl = ovl & 1;
            m_hist = 0; m_fill = 0; m_z = 0;
        end
        if (cl) begin
            m_hist = 0; m_fill = 0; m_z = 0; m_cnt = 0; m_cnt2 = 0;
        end
        if (!ld && !cl) begin
            if (xv) begin
                m_hist = ((m_hist << 1) | int'(xb)) & 15;
                if (m_fill < LEN) m_fill++;
                hit = (m_fill == LEN) && (((m_hist ^ m_pat) & m_mask) == 0);
                m_z = hit;
                if (hit) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (m_ovl == 0) m_fill = 0;
                end
            end else begin
                m_z = 0;
            end
        end
        #1;
        chk("z", z, 32'(m_z));
        chk("z_w2", z2, 32'(m_z));
        chk("match_count", cnt, 32'(m_cnt));
        chk("match_count_w2", cnt2, 32'(m_cnt2));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    initial begin
        reset = 1'b1; x = 0; x_valid = 0; clear = 0; cfg_load = 0;
        pattern = '0; mask = '0; overlap = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_z", z, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt_w2", cnt2, 0);
        @(negedge clk) reset = 1'b0;
        idle(3);

        // Default 10X1 pattern, non-overlap.
        step(1, 1); step(1, 0); step(1, 0); step(1, 1);
        chk("s1001_z", z, 1);
        chk("s1001_cnt", cnt, 1);
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);
        chk("s1011_z", z, 1);
        chk("s1011_cnt", cnt, 2);

        // Overlap with 1010.
        step(0, 0, 0, 1, 4'hA, 4'hF, 1);
        chk("ld_z", z, 0);
        chk("ld_keeps_cnt", cnt, 2);
        step(1, 1); step(1, 0); step(1, 1); step(1, 0);
        chk("ovl_bit4_z", z, 1);
        step(1, 1);
        chk("ovl_bit5_z", z, 0);
        step(1, 0);
        chk("ovl_bit6_z", z, 1);
        chk("ovl_cnt", cnt, 4);

        // Same stream without overlap.
        step(0, 0, 0, 1, 4'hA, 4'hF, 0);
        step(1, 1); step(1, 0); step(1, 1); step(1, 0);
        chk("novl_bit4_z", z, 1);
        step(1, 1); step(1, 0);
        chk("novl_bit6_z", z, 0);
        chk("novl_cnt", cnt, 5);

        // Gaps inside 1,0,0,1.
        step(0, 0, 0, 1, 4'h9, 4'hD, 0);
        step(1, 1); step(1, 0); idle(3); step(1, 0); step(1, 1);
        chk("gap_z", z, 1);
        chk("gap_cnt", cnt, 6);
        step(0, 0);
        chk("hit_to_armed_z", z, 0);

        // cfg_load mid-pattern discards the concurrent bit.
        step(1, 1); step(1, 0); step(1, 0);
        step(1, 1, 0, 1, 4'h9, 4'hD, 0);
        step(1, 1);
        chk("ld_mid_z", z, 0);
        chk("ld_mid_cnt", cnt, 6);
        step(1, 0); step(1, 0); step(1, 1);
        chk("pre_clear_z", z, 1);
        step(1, 1, 1, 0);
        chk("clear_z", z, 0);
        chk("clear_cnt", cnt, 0);

        // mask = 0: every accepted bit matches once filled.
        step(0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 1'($urandom_range(0, 1)));
        chk("sat_cnt", cnt, 5);
        chk("sat_cnt_w2", cnt2, 3);
        chk("mask0_z", z, 1);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            bit cl, ld;
            cl = ($urandom_range(0, 39) == 0);
            ld = ($urandom_range(0, 29) == 0);
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), cl, ld,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)));
        end

        // Asynchronous reset while z is high.
        step(0, 0, 0, 1, 4'h9, 4'hD, 0);
        step(1, 1); step(1, 0); step(1, 0); step(1, 1);
        chk("pre_rst_z", z, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_z", z, 0);
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_cnt_w2", cnt2, 0);
        model_reset();
        @(negedge clk) reset = 1'b0;
        idle(3);
        step(1, 0); step(1, 1); step(1, 0); step(1, 0); step(1, 1);
        chk("post_rst_z", z, 1);
        chk("post_rst_cnt", cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/masked_seq_detector.md
MASKED_SEQ_DETECTOR -- requirements
Module: masked_seq_detector

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port x  input  1  serial data bit.
REQ-006 SHALL have port x_valid  input  1  x is sampled only when high.
REQ-007 SHALL have port clear  input  1  synchronous flush of history, fill count, z and match_count.
REQ-008 SHALL have port cfg_load  input  1  latch pattern, mask and overlap into internal config registers.
REQ-009 SHALL have port pattern  input  LEN  target bits; pattern[LEN-1] is the oldest bit, pattern[0] the newest.
REQ-010 SHALL have port mask  input  LEN  care bits; 1 = compare, 0 = don't-care (X).
REQ-011 SHALL have port overlap  input  1  1 = overlapping matches allowed, 0 = history restarts after each match.
REQ-012 SHALL have port z  output  1  registered Moore match flag.
REQ-013 SHALL have port match_count  output  CNT_W  saturating count of matches.

Function
REQ-014 SHALL keep an LEN-bit history shift register; on each accepted bit, the register shifts left and x enters bit 0.
REQ-015 SHALL keep a fill counter 0..LEN; it increments on each accepted bit and saturates at LEN.
REQ-016 SHALL implement states FILL (fill < LEN), ARMED (fill = LEN, no match last cycle) and HIT (match detected on previous accepted bit).
REQ-017 SHALL declare a match on an accepted bit when the post-shift fill = LEN and ((history_next XOR pattern_r) AND mask_r) = 0.
REQ-018 SHALL enter HIT on the clock edge that accepts the completing bit; z = 1 only in HIT, so z rises one cycle after the completing bit is presented.
REQ-019 SHALL leave HIT on the next edge unless that edge also accepts a bit that produces a match; back-to-back matches hold z high.
REQ-020 SHALL hold state, history and fill unchanged, and SHALL return HIT to ARMED, on cycles where x_valid = 0.
REQ-021 SHALL, in non-overlap mode, reset fill to 0 on a match, so the next match needs LEN fresh bits; overlap mode SHALL retain history and fill.
REQ-022 SHALL increment match_count by 1 per match and SHALL saturate at 2^CNT_W-1.
REQ-023 SHALL treat mask_r = 0 as matching every accepted bit once fill = LEN.
REQ-024 SHALL, on cfg_load, update pattern_r, mask_r and overlap_r, zero history and fill, go to FILL and drop z; an x_valid bit in the same cycle SHALL be discarded; match_count SHALL be kept.
REQ-025 SHALL give clear priority over x_valid; clear and cfg_load in the same cycle SHALL perform both actions.

Reset
REQ-026 SHALL, on reset, set state FILL, history 0, fill 0, z 0 and match_count 0.
REQ-027 SHALL, on reset, set pattern_r 4'b1001 and mask_r 4'b1101 (the 10X1 pattern, low LEN bits zero-extended) and overlap_r 0.
REQ-028 SHALL release reset synchronously to clk.

Structure
REQ-029 SHALL place the state enum (FILL, ARMED, HIT) and the default pattern/mask constants in a shared package named seq_det_pkg.
REQ-030 SHALL use one sub-module, seq_det_history, for the history register, fill counter and masked compare; the top level SHALL hold the FSM, config registers and counter.

Verification
REQ-031 SHALL cover: reset defaults, stream 1,0,0,1 -> z=1 one cycle after the 4th bit, match_count=1; stream 1,0,1,1 -> second match.
REQ-032 SHALL cover: overlap=1, pattern 4'b1010, mask 4'hF, stream 1,0,1,0,1,0 -> z high after bits 4 and 6, match_count=2; the same stream with overlap=0 -> one match only.
REQ-033 SHALL cover: x_valid low for 3 cycles inside 1,0,0,1 -> match still detected; z never high during the gaps.
REQ-034 SHALL cover: CNT_W=2 with 5 matches -> match_count saturates at 3.
REQ-035 SHALL cover: cfg_load mid-pattern after 1,0,0 -> no match on the next bit 1; clear with x_valid in the same cycle -> bit dropped and z=0.
REQ-036 SHALL cover: reset asserted while z=1 -> z, match_count and fill become 0 immediately, with no clk edge required.
